// File: rtl/fir_pkg.sv
// Widths shared with fir_filter and the round/saturate helper that maps the
// N3-bit filter output onto an N2-bit sample.
package fir_pkg;

  localparam int N1 = 16;
  localparam int N2 = 16;
  localparam int N3 = 32;
  localparam int SHIFT = 15;

  localparam logic signed [N3:0] SAT_MAX = $signed({{(N3-N2+2){1'b0}}, {(N2-1){1'b1}}});
  localparam logic signed [N3:0] SAT_MIN = $signed({{(N3-N2+2){1'b1}}, {(N2-1){1'b0}}});

  // Returns {sat, sample}; one guard bit keeps the rounding add from wrapping.
  function automatic logic [N2:0] round_sat(input logic [N3-1:0] din, input int shift);
    logic signed [N3:0] half;
    logic signed [N3:0] r;
    half = (N3+1)'(1) <<< (shift - 1);
    r = ($signed({din[N3-1], din}) + half) >>> shift;
    if (r > SAT_MAX)
      round_sat = {1'b1, SAT_MAX[N2-1:0]};
    else if (r < SAT_MIN)
      round_sat = {1'b1, SAT_MIN[N2-1:0]};
    else
      round_sat = {1'b0, r[N2-1:0]};
  endfunction

endpackage

// File: rtl/fir_fwft_fifo.sv
// First-word-fall-through FIFO: a write is visible on rd_data the cycle after it lands.
// Full/empty come from level; a write when full only succeeds alongside a read.
module fir_fwft_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   level,
  output logic          not_empty
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_rd;
  logic          do_wr;

  assign not_empty = (level != '0);
  assign do_rd     = rd_en && not_empty;
  assign do_wr     = wr_en && ((level != FULL_LVL) || do_rd);
  assign rd_data   = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fir_output_capture.sv
// Captures FIR output after the fill samples, rounds/saturates to N2 bits and queues it;
// 2 cycles capture-to-visible. No backpressure to the filter: a full FIFO drops and flags.
module fir_output_capture #(
  parameter int N2    = 16,
  parameter int N3    = 32,
  parameter int SHIFT = 15,
  parameter int SKIP  = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ENABLE,
  input  logic [N3-1:0] fir_data,
  input  logic          clr_flags,
  output logic [N2-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          sat_flag,
  output logic [15:0]   sample_count
);

  import fir_pkg::*;

  localparam int          SW       = $clog2(SKIP + 1);
  localparam logic [SW-1:0] SKIP_END = SW'(SKIP);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  logic [SW-1:0] skip_cnt;
  logic          stage_valid;
  logic [N2-1:0] stage_data;
  logic [N2:0]   rs;
  logic          capture;
  logic          rd_fire;
  logic          wr_fire;
  logic          drop;

  assign rs      = round_sat(fir_data, SHIFT);
  assign capture = ENABLE && (skip_cnt == SKIP_END);
  assign rd_fire = out_valid && out_ready;
  assign wr_fire = stage_valid && ((level != FULL_LVL) || rd_fire);
  assign drop    = stage_valid && (level == FULL_LVL) && !rd_fire;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      skip_cnt     <= '0;
      stage_valid  <= 1'b0;
      stage_data   <= '0;
      overflow     <= 1'b0;
      sat_flag     <= 1'b0;
      sample_count <= '0;
    end else begin
      if (ENABLE && (skip_cnt != SKIP_END))
        skip_cnt <= skip_cnt + 1'b1;
      // The stage empties every cycle, written or dropped.
      stage_valid <= capture;
      if (capture)
        stage_data <= rs[N2-1:0];
      if (capture && rs[N2])
        sat_flag <= 1'b1;
      else if (clr_flags)
        sat_flag <= 1'b0;
      if (drop)
        overflow <= 1'b1;
      else if (clr_flags)
        overflow <= 1'b0;
      if (wr_fire)
        sample_count <= sample_count + 1'b1;
    end
  end

  fir_fwft_fifo #(
    .W     (N2),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .wr_en     (wr_fire),
    .wr_data   (stage_data),
    .rd_en     (rd_fire),
    .rd_data   (out_data),
    .level     (level),
    .not_empty (out_valid)
  );

endmodule

// File: tb/tb_fir_output_capture.sv
// Directed bench for fir_output_capture: skip, rounding table, overflow, full-rate
// streaming, enable gaps, flag clearing and asynchronous reset mid-stream.
module tb_fir_output_capture;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ENABLE;
  logic [31:0] fir_data;
  logic        clr_flags;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic        overflow;
  logic        sat_flag;
  logic [15:0] sample_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt;

  typedef struct {
    logic [31:0] din;
    logic [15:0] dout;
    logic        sat;
  } rvec_t;

  rvec_t       rv [10];
  logic [15:0] gap_exp [5];

  always #5 CLK = ~CLK;

  fir_output_capture dut (
    .CLK          (CLK),
    .RST          (RST),
    .ENABLE       (ENABLE),
    .fir_data     (fir_data),
    .clr_flags    (clr_flags),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .overflow     (overflow),
    .sat_flag     (sat_flag),
    .sample_count (sample_count)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    ENABLE   = 1'b1;
    fir_data = d;
    cyc();
  endtask

  task automatic idle();
    ENABLE = 1'b0;
    cyc();
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
  endtask

  task automatic flush();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && out_valid; i++)
      cyc();
    out_ready = 1'b0;
    chk("flush_empty", {31'b0, out_valid}, 32'd0);
  endtask

  task automatic drain_seq(input int first, input int last, input string tag);
    out_ready = 1'b1;
    for (int v = first; v <= last; v++) begin
      chk($sformatf("%s_valid%0d", tag, v), {31'b0, out_valid}, 32'd1);
      chk($sformatf("%s_data%0d", tag, v), {16'b0, out_data}, v);
      cyc();
    end
    out_ready = 1'b0;
    chk($sformatf("%s_empty", tag), {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    RST       = 1'b1;
    ENABLE    = 1'b0;
    fir_data  = '0;
    clr_flags = 1'b0;
    out_ready = 1'b0;
    exp_cnt   = '0;

    rv[0] = '{32'h3FFF_8000, 16'h7FFF, 1'b0};
    rv[1] = '{32'h4000_0000, 16'h7FFF, 1'b1};
    rv[2] = '{32'hFFFF_C000, 16'h0000, 1'b0};
    rv[3] = '{32'hC000_0000, 16'h8000, 1'b0};
    rv[4] = '{32'hBFFF_0000, 16'h8000, 1'b1};
    rv[5] = '{32'h0000_3FFF, 16'h0000, 1'b0};
    rv[6] = '{32'hFFFF_8000, 16'hFFFF, 1'b0};
    rv[7] = '{32'h7FFF_FFFF, 16'h7FFF, 1'b1};
    rv[8] = '{32'h8000_0000, 16'h8000, 1'b1};
    rv[9] = '{32'h0001_8000, 16'h0003, 1'b0};

    gap_exp[0] = 16'h7FFF;
    gap_exp[1] = 16'h0003;
    gap_exp[2] = 16'h0005;
    gap_exp[3] = 16'h0007;
    gap_exp[4] = 16'h8000;

    // Reset state
    cyc();
    cyc();
    chk("rst_out_data", {16'b0, out_data}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_level", {27'b0, level}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_sat_flag", {31'b0, sat_flag}, 32'd0);
    chk("rst_count", {16'b0, sample_count}, 32'd0);
    RST = 1'b0;

    // Skip of the fill samples
    for (int i = 0; i < 9; i++)
      push(32'h0000_4000);
    chk("skip_level", {27'b0, level}, 32'd0);
    chk("skip_count", {16'b0, sample_count}, 32'd0);
    push(32'h0000_4000);
    idle();
    exp_cnt = exp_cnt + 16'd2;
    chk("skip_after_level", {27'b0, level}, 32'd2);
    chk("skip_after_data", {16'b0, out_data}, 32'h0001);
    chk("skip_after_valid", {31'b0, out_valid}, 32'd1);
    chk("skip_after_count", {16'b0, sample_count}, {16'b0, exp_cnt});
    flush();
    pulse_clr();

    // Rounding / saturation table
    for (int i = 0; i < 10; i++) begin
      push(rv[i].din);
      idle();
      exp_cnt = exp_cnt + 16'd1;
      chk($sformatf("round%0d_data", i), {16'b0, out_data}, {16'b0, rv[i].dout});
      chk($sformatf("round%0d_sat", i), {31'b0, sat_flag}, {31'b0, rv[i].sat});
      flush();
      pulse_clr();
    end
    chk("round_count", {16'b0, sample_count}, {16'b0, exp_cnt});

    // Fill past capacity with no reads
    for (int i = 1; i <= 18; i++)
      push(32'(i) << 15);
    idle();
    exp_cnt = exp_cnt + 16'd16;
    chk("full_level", {27'b0, level}, 32'd16);
    chk("full_overflow", {31'b0, overflow}, 32'd1);
    chk("full_count", {16'b0, sample_count}, {16'b0, exp_cnt});
    pulse_clr();
    chk("ovf_clr", {31'b0, overflow}, 32'd0);
    drain_seq(1, 16, "full");

    // Full FIFO streaming with simultaneous read and write
    for (int i = 1; i <= 17; i++)
      push(32'(i) << 15);
    chk("stream_pre_level", {27'b0, level}, 32'd16);
    for (int j = 18; j <= 25; j++) begin
      out_ready = 1'b1;
      push(32'(j) << 15);
      chk($sformatf("stream_level%0d", j), {27'b0, level}, 32'd16);
      chk($sformatf("stream_head%0d", j), {16'b0, out_data}, j - 16);
    end
    ENABLE = 1'b0;
    drain_seq(9, 25, "stream");
    exp_cnt = exp_cnt + 16'd25;
    chk("stream_overflow", {31'b0, overflow}, 32'd0);
    chk("stream_count", {16'b0, sample_count}, {16'b0, exp_cnt});

    // Enable gaps
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        push((i == 0) ? 32'h7FFF_FFFF : (32'(i + 1) << 15));
      else
        idle();
    end
    exp_cnt = exp_cnt + 16'd4;
    chk("gap_count", {16'b0, sample_count}, {16'b0, exp_cnt});
    chk("gap_level", {27'b0, level}, 32'd4);
    chk("gap_sat", {31'b0, sat_flag}, 32'd1);
    // Saturating capture on the same edge as the clear keeps the flag set
    clr_flags = 1'b1;
    push(32'h8000_0000);
    clr_flags = 1'b0;
    chk("sat_set_wins", {31'b0, sat_flag}, 32'd1);
    idle();
    exp_cnt = exp_cnt + 16'd1;
    pulse_clr();
    chk("clr_sat", {31'b0, sat_flag}, 32'd0);
    chk("clr_overflow", {31'b0, overflow}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("gap_data%0d", i), {16'b0, out_data}, {16'b0, gap_exp[i]});
      cyc();
    end
    out_ready = 1'b0;
    chk("gap_empty", {31'b0, out_valid}, 32'd0);
    chk("gap_final_count", {16'b0, sample_count}, {16'b0, exp_cnt});

    // Asynchronous reset mid-stream
    for (int i = 1; i <= 5; i++)
      push(32'(i) << 15);
    idle();
    chk("mid_level", {27'b0, level}, 32'd5);
    #3;
    RST = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_level", {27'b0, level}, 32'd0);
    chk("arst_data", {16'b0, out_data}, 32'd0);
    chk("arst_count", {16'b0, sample_count}, 32'd0);
    cyc();
    RST = 1'b0;
    exp_cnt = '0;
    for (int i = 0; i < 8; i++)
      push(32'h0000_8000);
    idle();
    chk("post_rst_skip_level", {27'b0, level}, 32'd0);
    push(32'h0001_8000);
    idle();
    exp_cnt = exp_cnt + 16'd1;
    chk("post_rst_level", {27'b0, level}, 32'd1);
    chk("post_rst_data", {16'b0, out_data}, 32'h0003);
    chk("post_rst_count", {16'b0, sample_count}, {16'b0, exp_cnt});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_output_capture.md
Name: fir_output_capture

Overview:
- Consumer end of the FIR filter's output stream: samples the filter's 32-bit output_data on every enabled clock and discards the pipeline-fill samples.
- Rounds and saturates each sample to 16 bits and buffers it in a first-word-fall-through FIFO.
- Downstream logic drains the FIFO over a valid/ready handshake.
- Replaces file-dump capture of filter results in the datapath; sits directly after fir_filter.

Parameters:
- N2, 16, output sample width (signed).
- N3, 32, FIR output width (signed).
- SHIFT, 15, arithmetic right-shift applied before saturation; must be 1..N3-N2.
- SKIP, 8, number of enabled samples discarded after reset (filter fill, = tap count).
- DEPTH, 16, FIFO entries; power of two.
- AW, 4, log2(DEPTH).

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  same enable driven to fir_filter; qualifies fir_data each cycle.
- fir_data  in  N3  FIR output_data, signed.
- clr_flags  in  1  synchronous clear of overflow and sat_flag.
- out_data  out  N2  head-of-FIFO sample, signed.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts out_data when high with out_valid.
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- sat_flag  out  1  sticky: at least one sample saturated.
- sample_count  out  16  number of samples written to the FIFO; wraps at 0xFFFF to 0.

Behaviour:
- Reset (async, RST=1): skip counter, stage valid, FIFO pointers, level, overflow, sat_flag and sample_count all reset to 0. out_valid=0; out_data=0.
- Capture: on each rising edge with ENABLE=1, the skip counter increments until it reaches SKIP.
  - Samples seen while the counter is below SKIP are discarded.
  - Later samples load the stage register; stage_valid is set.
- ENABLE=0: nothing is captured, the skip counter holds, and the stage still drains.
- Arithmetic, computed in N3+1 bits:
  - r = (sext(fir_data) + 2^(SHIFT-1)) >>> SHIFT.
  - If r > 2^(N2-1)-1, clamp to 0x7FFF and set sat_flag.
  - If r < -2^(N2-1), clamp to 0x8000 and set sat_flag.
  - Otherwise take the low N2 bits.
  - The result is computed combinationally from fir_data and registered in the stage.
- Latency: a sample captured at edge k is written to the FIFO at edge k+1. out_valid/out_data reflect it after edge k+1 if the FIFO was empty (first-word fall-through), giving 2 cycles capture-to-visible.
- FIFO write: a pending stage sample is written when level<DEPTH, or when level==DEPTH and a read occurs on the same edge. In both cases sample_count increments.
- FIFO full, no read: the stage sample is dropped, overflow is set, and the stage is still consumed (no backpressure to the filter).
- Read: out_valid & out_ready pops the head entry. out_ready with an empty FIFO has no effect.
- Simultaneous read and write: level is unchanged and the pointers both advance.
- clr_flags: clears overflow and sat_flag on the next edge. A set event on the same edge wins.
- RST mid-stream: all buffered and staged data is lost immediately, and SKIP samples are discarded again after release.
- Pointers are AW-bit and wrap modulo DEPTH; full/empty are derived from level.

Decomposition:
- Package fir_pkg:
  - width constants N1/N2/N3 shared with fir_filter;
  - SHIFT default;
  - function round_sat(N3 in) returning {sat, N2 out}.
- One sub-module: fir_fwft_fifo (DEPTH x N2, write/read enables, level, FWFT output). The top holds the skip counter, stage, flags and counter.

Test Plan:
- Reset/skip:
  - Stimulus: RST=1 for 2 cycles, then ENABLE=1 with fir_data=0x0000_4000 for 10 cycles, out_ready=0.
  - Required: all outputs 0 during reset; the first 8 samples are dropped; level=2, out_data=0x0001 (rounding of 0.5 LSB up), sample_count=2.
- Rounding/saturation, one sample each:
  - 0x3FFF_8000 -> 0x7FFF, sat_flag=0.
  - 0x4000_0000 -> 0x7FFF, sat_flag=1.
  - 0xFFFF_C000 -> 0x0000.
  - 0xC000_0000 -> 0x8000, no sat.
  - 0xBFFF_0000 -> 0x8000, sat_flag=1.
- Full/overflow:
  - Stimulus: out_ready=0, 18 post-skip samples with distinct values.
  - Required: level=16, overflow=1, sample_count=16; drained order equals the first 16 inputs.
- Simultaneous read/write at full:
  - Stimulus: level=16, out_ready=1, ENABLE continuous.
  - Required: level stays 16, no overflow, outputs in input order.
- ENABLE gaps and clr_flags:
  - Stimulus: alternate ENABLE 1/0, then pulse clr_flags.
  - Required: only enabled samples are counted; overflow and sat_flag read 0 the cycle after the pulse.
- Reset mid-operation:
  - Stimulus: assert RST asynchronously with level=5.
  - Required: out_valid=0 and level=0 before the next clock edge; the next 8 enabled samples are discarded.
